// File: rtl/wb_dual_arbiter.sv
// Two-master Wishbone arbiter: registered round-robin grant held for the owner's
// whole cyc tenure, owner-only ack/err routing, and a hung-transfer timeout err.
module wb_dual_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [31:0]  i_m0_adr,
   input  logic [15:0]  i_m0_sel,
   input  logic         i_m0_we,
   input  logic [127:0] i_m0_dat,
   input  logic         i_m0_cyc,
   input  logic         i_m0_stb,
   output logic [127:0] o_m0_dat,
   output logic         o_m0_ack,
   output logic         o_m0_err,
   input  logic [31:0]  i_m1_adr,
   input  logic [15:0]  i_m1_sel,
   input  logic         i_m1_we,
   input  logic [127:0] i_m1_dat,
   input  logic         i_m1_cyc,
   input  logic         i_m1_stb,
   output logic [127:0] o_m1_dat,
   output logic         o_m1_ack,
   output logic         o_m1_err,
   output logic [31:0]  o_s_adr,
   output logic [15:0]  o_s_sel,
   output logic         o_s_we,
   output logic [127:0] o_s_dat,
   output logic         o_s_cyc,
   output logic         o_s_stb,
   input  logic [127:0] i_s_dat,
   input  logic         i_s_ack,
   input  logic         i_s_err,
   output logic [1:0]   o_grant,
   output logic         o_timeout
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      r_state, w_state_nxt;
   logic        r_last, w_last_nxt;
   logic [7:0]  r_wait_cnt, w_wait_cnt_nxt;
   logic        w_req0, w_req1;
   logic        w_stb_raw, w_fire;
   logic        w_own0, w_own1;

   assign w_req0 = i_m0_cyc & i_m0_stb;
   assign w_req1 = i_m1_cyc & i_m1_stb;
   assign w_own0 = (r_state == OWN0);
   assign w_own1 = (r_state == OWN1);

   // On a simultaneous request the master that was not granted last wins.
   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            if (w_req0 && (!w_req1 || r_last)) begin
               w_state_nxt = OWN0;
               w_last_nxt  = 1'b0;
            end else if (w_req1) begin
               w_state_nxt = OWN1;
               w_last_nxt  = 1'b1;
            end
         end
         OWN0:    if (!i_m0_cyc) w_state_nxt = IDLE;
         OWN1:    if (!i_m1_cyc) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_s_adr   = '0;
      o_s_sel   = '0;
      o_s_we    = 1'b0;
      o_s_dat   = '0;
      o_s_cyc   = 1'b0;
      w_stb_raw = 1'b0;
      o_grant   = 2'b00;
      case (r_state)
         OWN0: begin
            o_s_adr   = i_m0_adr;
            o_s_sel   = i_m0_sel;
            o_s_we    = i_m0_we;
            o_s_dat   = i_m0_dat;
            o_s_cyc   = i_m0_cyc;
            w_stb_raw = i_m0_stb;
            o_grant   = 2'b01;
         end
         OWN1: begin
            o_s_adr   = i_m1_adr;
            o_s_sel   = i_m1_sel;
            o_s_we    = i_m1_we;
            o_s_dat   = i_m1_dat;
            o_s_cyc   = i_m1_cyc;
            w_stb_raw = i_m1_stb;
            o_grant   = 2'b10;
         end
         default: ;
      endcase
   end

   // A real slave response on the would-be timeout cycle takes priority.
   assign w_fire    = (r_wait_cnt == TO_LAST) & w_stb_raw & ~i_s_ack & ~i_s_err;
   assign o_s_stb   = w_stb_raw & ~w_fire;
   assign o_timeout = w_fire;

   assign o_m0_ack = w_own0 & i_s_ack & o_s_stb;
   assign o_m1_ack = w_own1 & i_s_ack & o_s_stb;
   assign o_m0_err = w_own0 & ((i_s_err & o_s_stb) | w_fire);
   assign o_m1_err = w_own1 & ((i_s_err & o_s_stb) | w_fire);

   assign o_m0_dat = i_s_dat;
   assign o_m1_dat = i_s_dat;

   always_comb begin
      w_wait_cnt_nxt = 8'd0;
      if (o_s_stb && !i_s_ack && !i_s_err && (w_state_nxt == r_state))
         w_wait_cnt_nxt = r_wait_cnt + 8'd1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_last     <= 1'b1;
         r_wait_cnt <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_last     <= w_last_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_wb_dual_arbiter.sv
// Directed bench for wb_dual_arbiter: per-cycle vector table plus hand-written
// latency / stall-clear / timeout-pulse sequence.
module tb_wb_dual_arbiter;

   localparam int TO = 8;
   localparam logic [31:0]  ADR0 = 32'h0000_0100;
   localparam logic [31:0]  ADR1 = 32'h0000_0200;
   localparam logic [15:0]  SEL0 = 16'h00FF;
   localparam logic [15:0]  SEL1 = 16'hF0F0;
   localparam logic [127:0] DAT0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
   localparam logic [127:0] DAT1 = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
   localparam logic [127:0] SDAT = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_DEAD_BEEF;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  m0_adr, m1_adr;
   logic [15:0]  m0_sel, m1_sel;
   logic         m0_we, m1_we;
   logic [127:0] m0_dat_i, m1_dat_i;
   logic         m0_cyc, m0_stb, m1_cyc, m1_stb;
   logic [127:0] m0_dat_o, m1_dat_o;
   logic         m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0]  s_adr;
   logic [15:0]  s_sel;
   logic         s_we, s_cyc, s_stb;
   logic [127:0] s_dat_o, s_dat_i;
   logic         s_ack, s_err;
   logic [1:0]   grant;
   logic         timeout;

   int nvec  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   wb_dual_arbiter #(.TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m0_adr(m0_adr), .i_m0_sel(m0_sel), .i_m0_we(m0_we), .i_m0_dat(m0_dat_i),
      .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb),
      .o_m0_dat(m0_dat_o), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
      .i_m1_adr(m1_adr), .i_m1_sel(m1_sel), .i_m1_we(m1_we), .i_m1_dat(m1_dat_i),
      .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb),
      .o_m1_dat(m1_dat_o), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
      .o_s_adr(s_adr), .o_s_sel(s_sel), .o_s_we(s_we), .o_s_dat(s_dat_o),
      .o_s_cyc(s_cyc), .o_s_stb(s_stb),
      .i_s_dat(s_dat_i), .i_s_ack(s_ack), .i_s_err(s_err),
      .o_grant(grant), .o_timeout(timeout)
   );

   typedef struct {
      bit       rst_n, c0, s0, c1, s1, ack, err;
      bit [1:0] g;
      bit       a0, e0, a1, e1, scyc, sstb, to;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t V(bit rst, bit c0, bit s0, bit c1, bit s1, bit ack, bit err,
                              bit [1:0] g, bit a0, bit e0, bit a1, bit e1,
                              bit scyc, bit sstb, bit to);
      vec_t v;
      v.rst_n = rst; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack; v.err = err;
      v.g = g; v.a0 = a0; v.e0 = e0; v.a1 = a1; v.e1 = e1;
      v.scyc = scyc; v.sstb = sstb; v.to = to;
      return v;
   endfunction

   task automatic cmp(input string nm, input string f, input logic [127:0] got,
                      input logic [127:0] exp);
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s %s: got %0h expected %0h", nm, f, got, exp);
      end
   endtask

   task automatic check_vec(input string nm, input vec_t v);
      logic [31:0]  e_adr;
      logic [15:0]  e_sel;
      logic [127:0] e_dat;
      logic         e_we;
      e_adr = 32'd0; e_sel = 16'd0; e_dat = 128'd0; e_we = 1'b0;
      if (v.g == 2'b01) begin
         e_adr = ADR0; e_sel = SEL0; e_dat = DAT0; e_we = 1'b0;
      end else if (v.g == 2'b10) begin
         e_adr = ADR1; e_sel = SEL1; e_dat = DAT1; e_we = 1'b1;
      end
      nvec++;
      cmp(nm, "grant",   128'(grant),   128'(v.g));
      cmp(nm, "m0_ack",  128'(m0_ack),  128'(v.a0));
      cmp(nm, "m0_err",  128'(m0_err),  128'(v.e0));
      cmp(nm, "m1_ack",  128'(m1_ack),  128'(v.a1));
      cmp(nm, "m1_err",  128'(m1_err),  128'(v.e1));
      cmp(nm, "s_cyc",   128'(s_cyc),   128'(v.scyc));
      cmp(nm, "s_stb",   128'(s_stb),   128'(v.sstb));
      cmp(nm, "timeout", 128'(timeout), 128'(v.to));
      cmp(nm, "s_adr",   128'(s_adr),   128'(e_adr));
      cmp(nm, "s_sel",   128'(s_sel),   128'(e_sel));
      cmp(nm, "s_we",    128'(s_we),    128'(e_we));
      cmp(nm, "s_dat",   s_dat_o,       e_dat);
      cmp(nm, "m0_dat",  m0_dat_o,      SDAT);
      cmp(nm, "m1_dat",  m1_dat_o,      SDAT);
   endtask

   initial begin
      int lat;
      m0_adr = ADR0; m0_sel = SEL0; m0_we = 1'b0; m0_dat_i = DAT0;
      m1_adr = ADR1; m1_sel = SEL1; m1_we = 1'b1; m1_dat_i = DAT1;
      s_dat_i = SDAT;
      rst_n = 1'b0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; s_err = 0;
      repeat (2) @(posedge clk);

      // single m0 read, acked two cycles after grant
      tbl.push_back(V(0,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0));
      tbl.push_back(V(1,1,1,0,0,0,0,2'b00,0,0,0,0,0,0,0));
      tbl.push_back(V(1,1,1,0,0,0,0,2'b01,0,0,0,0,1,1,0));
      tbl.push_back(V(1,1,1,0,0,0,0,2'b01,0,0,0,0,1,1,0));
      tbl.push_back(V(1,1,1,0,0,1,0,2'b01,1,0,0,0,1,1,0));
      tbl.push_back(V(1,0,0,0,0,0,0,2'b01,0,0,0,0,0,0,0));
      tbl.push_back(V(1,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0));
      // re-reset, then simultaneous contests alternate 0,1,0,1
      tbl.push_back(V(0,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0));
      tbl.push_back(V(1,1,1,1,1,0,0,2'b00,0,0,0,0,0,0,0));
      tbl.push_back(V(1,1,1,1,1,1,0,2'b01,1,0,0,0,1,1,0));
      tbl.push_back(V(1,0,0,1,1,0,0,2'b01,0,0,0,0,0,0,0));
      tbl.push_back(V(1,0,0,1,1,0,0,2'b00,0,0,0,0,0,0,0));
      tbl.push_back(V(1,0,0,1,1,1,0,2'b10,0,0,1,0,1,1,0));
      tbl.push_back(V(1,0,0,0,0,0,0,2'b10,0,0,0,0,0,0,0));
      tbl.push_back(V(1,1,1,1,1,0,0,2'b00,0,0,0,0,0,0,0));
      tbl.push_back(V(1,1,1,1,1,1,0,2'b01,1,0,0,0,1,1,0));
      tbl.push_back(V(1,0,0,0,0,0,0,2'b01,0,0,0,0,0,0,0));
      tbl.push_back(V(1,1,1,1,1,0,0,2'b00,0,0,0,0,0,0,0));
      tbl.push_back(V(1,1,1,1,1,1,0,2'b10,0,0,1,0,1,1,0));
      tbl.push_back(V(1,0,0,0,0,0,0,2'b10,0,0,0,0,0,0,0));
      // m1 keeps cyc across three write strobes while m0 waits
      tbl.push_back(V(1,0,0,1,1,0,0,2'b00,0,0,0,0,0,0,0));
      tbl.push_back(V(1,1,1,1,1,1,0,2'b10,0,0,1,0,1,1,0));
      tbl.push_back(V(1,1,1,1,0,0,0,2'b10,0,0,0,0,1,0,0));
      tbl.push_back(V(1,1,1,1,1,1,0,2'b10,0,0,1,0,1,1,0));
      tbl.push_back(V(1,1,1,1,1,1,0,2'b10,0,0,1,0,1,1,0));
      tbl.push_back(V(1,1,1,0,0,0,0,2'b10,0,0,0,0,0,0,0));
      tbl.push_back(V(1,1,1,0,0,0,0,2'b00,0,0,0,0,0,0,0));
      // m0 unanswered: timeout on the 8th strobed cycle, then ack wins on the fire cycle
      repeat (7) tbl.push_back(V(1,1,1,0,0,0,0,2'b01,0,0,0,0,1,1,0));
      tbl.push_back(V(1,1,1,0,0,0,0,2'b01,0,1,0,0,1,0,1));
      repeat (7) tbl.push_back(V(1,1,1,0,0,0,0,2'b01,0,0,0,0,1,1,0));
      tbl.push_back(V(1,1,1,0,0,1,0,2'b01,1,0,0,0,1,1,0));
      tbl.push_back(V(1,0,0,0,0,0,0,2'b01,0,0,0,0,0,0,0));
      // slave err on m1 clears the wait counter
      tbl.push_back(V(1,0,0,1,1,0,0,2'b00,0,0,0,0,0,0,0));
      repeat (2) tbl.push_back(V(1,0,0,1,1,0,0,2'b10,0,0,0,0,1,1,0));
      tbl.push_back(V(1,0,0,1,1,0,1,2'b10,0,0,0,1,1,1,0));
      repeat (7) tbl.push_back(V(1,0,0,1,1,0,0,2'b10,0,0,0,0,1,1,0));
      tbl.push_back(V(1,0,0,1,1,0,0,2'b10,0,0,0,1,1,0,1));
      tbl.push_back(V(1,0,0,0,0,0,0,2'b10,0,0,0,0,0,0,0));
      tbl.push_back(V(1,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0));
      // reset mid-access; the late ack must not reach m0
      tbl.push_back(V(1,1,1,0,0,0,0,2'b00,0,0,0,0,0,0,0));
      tbl.push_back(V(0,1,1,0,0,0,0,2'b01,0,0,0,0,1,1,0));
      tbl.push_back(V(1,1,1,0,0,1,0,2'b00,0,0,0,0,0,0,0));
      tbl.push_back(V(1,0,0,0,0,0,0,2'b01,0,0,0,0,0,0,0));
      tbl.push_back(V(1,0,0,0,0,0,0,2'b00,0,0,0,0,0,0,0));

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         rst_n = tbl[i].rst_n;
         m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0;
         m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1;
         s_ack = tbl[i].ack; s_err = tbl[i].err;
         #3;
         check_vec($sformatf("vec%0d", i), tbl[i]);
      end

      // grant latency, then a stb gap must clear the wait counter while keeping ownership
      @(posedge clk); #1;
      rst_n = 1; m0_cyc = 1; m0_stb = 1; m1_cyc = 0; m1_stb = 0; s_ack = 0; s_err = 0;
      #3;
      nvec++; cmp("hs_idle", "grant", 128'(grant), 128'(2'b00));
      lat = 0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #4;
         if (grant == 2'b01) begin lat = i; break; end
      end
      nvec++; cmp("hs_grant_latency", "cycles", 128'(lat), 128'(1));
      repeat (4) @(posedge clk);
      #1 m0_stb = 0; #3;
      nvec++; cmp("hs_stb_gap", "grant", 128'(grant), 128'(2'b01));
      nvec++; cmp("hs_stb_gap", "s_cyc/s_stb/timeout", 128'({s_cyc, s_stb, timeout}), 128'(3'b100));
      @(posedge clk); #1 m0_stb = 1; #3;
      nvec++; cmp("hs_restrobe", "timeout", 128'(timeout), 128'(0));
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #4;
         if (timeout) begin lat = i; break; end
      end
      nvec++; cmp("hs_timeout_latency", "cycles", 128'(lat), 128'(TO - 1));
      nvec++; cmp("hs_timeout_cycle", "m0_err/s_stb/m1_err", 128'({m0_err, s_stb, m1_err}), 128'(3'b100));
      @(posedge clk); #4;
      nvec++; cmp("hs_timeout_pulse", "timeout/m0_err", 128'({timeout, m0_err}), 128'(2'b00));
      @(posedge clk); #1 m0_cyc = 0; m0_stb = 0; #3;
      @(posedge clk); #4;
      nvec++; cmp("hs_release", "grant/s_cyc", 128'({grant, s_cyc}), 128'(3'b000));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
